// File: rtl/noc_fault_inject_ctrl.sv
// Fault-injection controller: decodes multi-flit host commands into per-node
// link-fault enables, with permanent set/clear and auto-expiring transients.
module noc_fault_inject_ctrl #(
  parameter int X       = 3,
  parameter int Y       = 3,
  parameter int LINKS   = 8,
  parameter int TIMER_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // Command flit packed as {valid, last, data[15:0]}.
  input  logic [17:0]                  flit_in,
  output logic                         flit_in_ready,
  output logic [X*Y-1:0][LINKS-1:0]    fim_en,
  output logic                         cmd_done,
  output logic                         cmd_err
);

  localparam int NODES = X * Y;
  localparam int NW    = (NODES > 1) ? $clog2(NODES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MASK, S_DUR, S_DRAIN} state_e;
  typedef enum logic [1:0] {OP_SET, OP_CLR, OP_TRANS, OP_CLR_ALL} op_e;

  logic        flit_valid;
  logic        flit_last;
  logic [15:0] flit_data;
  logic [3:0]  hdr_opcode;
  logic [7:0]  hdr_node;
  logic        hdr_ok;

  assign flit_valid = flit_in[17];
  assign flit_last  = flit_in[16];
  assign flit_data  = flit_in[15:0];
  assign hdr_opcode = flit_data[15:12];
  assign hdr_node   = flit_data[7:0];
  assign hdr_ok     = (hdr_opcode <= 4'd3) && (hdr_node < 8'(NODES));

  state_e            state_q;
  op_e               op_q;
  logic [NW-1:0]     node_q;
  logic [LINKS-1:0]  mask_q;
  logic              done_q;
  logic              err_q;
  logic              ready_q;

  logic [NODES-1:0][LINKS-1:0]   perm_q,  perm_d;
  logic [NODES-1:0][LINKS-1:0]   trans_q, trans_d;
  logic [NODES-1:0][TIMER_W-1:0] timer_q, timer_d;
  logic [NODES-1:0][LINKS-1:0]   fim_en_q, fim_en_d;

  // A command takes effect only on its well-formed final flit.
  logic commit_set, commit_clr, commit_trans, commit_clr_all;

  assign commit_set     = flit_valid && flit_last && (state_q == S_MASK) && (op_q == OP_SET);
  assign commit_clr     = flit_valid && flit_last && (state_q == S_MASK) && (op_q == OP_CLR);
  assign commit_trans   = flit_valid && flit_last && (state_q == S_DUR);
  assign commit_clr_all = flit_valid && flit_last && (state_q == S_IDLE) && hdr_ok
                          && (hdr_opcode == 4'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SET;
      node_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (flit_valid) begin
        unique case (state_q)
          S_IDLE: begin
            op_q   <= op_e'(hdr_opcode[1:0]);
            node_q <= hdr_node[NW-1:0];
            if (!hdr_ok) begin
              err_q   <= 1'b1;
              state_q <= flit_last ? S_IDLE : S_DRAIN;
            end else if (hdr_opcode == 4'd3) begin
              if (flit_last) begin
                done_q <= 1'b1;
              end else begin
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end
            end else if (flit_last) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_MASK;
            end
          end
          S_MASK: begin
            mask_q <= flit_data[LINKS-1:0];
            if (op_q == OP_TRANS) begin
              if (flit_last) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DUR;
              end
            end else begin
              done_q  <= flit_last;
              err_q   <= !flit_last;
              state_q <= flit_last ? S_IDLE : S_DRAIN;
            end
          end
          S_DUR: begin
            done_q  <= flit_last;
            err_q   <= !flit_last;
            state_q <= flit_last ? S_IDLE : S_DRAIN;
          end
          S_DRAIN: begin
            if (flit_last) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Expiry is applied first; an explicit command on the same node overrides it.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so the
    // block stays purely combinational.
    perm_d  = perm_q;
    trans_d = trans_q;
    timer_d = timer_q;
    for (int n = 0; n < NODES; n++) begin
      if (timer_q[n] != '0) timer_d[n] = timer_q[n] - TIMER_W'(1);
      if (timer_q[n] == TIMER_W'(1)) trans_d[n] = '0;
    end

    if (commit_set) begin
      perm_d[node_q] = perm_q[node_q] | flit_data[LINKS-1:0];
    end
    if (commit_clr) begin
      perm_d[node_q]  = perm_q[node_q]  & ~flit_data[LINKS-1:0];
      trans_d[node_q] = trans_q[node_q] & ~flit_data[LINKS-1:0];
    end
    if (commit_trans) begin
      trans_d[node_q] = mask_q;
      timer_d[node_q] = flit_data[TIMER_W-1:0];
    end
    if (commit_clr_all) begin
      perm_d  = '0;
      trans_d = '0;
      timer_d = '0;
    end

    for (int n = 0; n < NODES; n++) begin
      fim_en_d[n] = perm_d[n] | ((timer_d[n] != '0) ? trans_d[n] : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the fault state is reset explicitly; it drives live fault enables
      // and must never come up with stale faults injected.
      perm_q   <= '0;
      trans_q  <= '0;
      timer_q  <= '0;
      fim_en_q <= '0;
    end else begin
      perm_q   <= perm_d;
      trans_q  <= trans_d;
      timer_q  <= timer_d;
      fim_en_q <= fim_en_d;
    end
  end

  assign flit_in_ready = ready_q;
  assign fim_en        = fim_en_q;
  assign cmd_done      = done_q;
  assign cmd_err       = err_q;

endmodule
